reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/constants_pkg.sv | 6 +
 rtl/instruction_pkg.sv | 16 +
 rtl/reorder_buffer_if.sv | 48 ++++
 rtl/reorder_buffer.sv | 112 +++++++++++
 tb/tb_reorder_buffer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/constants_pkg.sv
// Architecture-wide sizing constants shared by the pipeline blocks.
package constants_pkg;
  localparam int ARCH_LEN     = 32;
  localparam int REG_FILE_LEN = 32;
  localparam int ROB_DEPTH    = 8;
endpackage

// File: rtl/instruction_pkg.sv
// Instruction-level record types; rob_entry_t is one reorder-buffer slot.
package instruction_pkg;
  import constants_pkg::*;

  localparam int ENTRY_REG_W = $clog2(REG_FILE_LEN);

  typedef struct packed {
    logic                   busy;
    logic                   done;
    logic                   exc;
    logic                   we;
    logic                   is_store;
    logic [ENTRY_REG_W-1:0] dst_reg;
    logic [ARCH_LEN-1:0]    data;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Signal bundle around the reorder buffer: decode allocate, result writeback,
// in-order commit and flush. master = pipeline side, slave = buffer side.
interface reorder_buffer_if
  import constants_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = ARCH_LEN,
  parameter int REG_W  = $clog2(REG_FILE_LEN)
);
  localparam int ID_W = $clog2(DEPTH);

  logic              alloc_valid;
  logic              alloc_ready;
  logic [REG_W-1:0]  alloc_dst_reg;
  logic              alloc_we;
  logic              alloc_is_store;
  logic [ID_W-1:0]   alloc_id;
  logic              wb_valid;
  logic [ID_W-1:0]   wb_id;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exc;
  logic              commit_valid;
  logic              commit_ready;
  logic [ID_W-1:0]   commit_id;
  logic [REG_W-1:0]  commit_dst_reg;
  logic [DATA_W-1:0] commit_data;
  logic              commit_we;
  logic              commit_is_store;
  logic              commit_exc;
  logic              flush;
  logic [ID_W:0]     count;
  logic              empty;
  logic              full;

  modport master (
    output alloc_valid, alloc_dst_reg, alloc_we, alloc_is_store,
    output wb_valid, wb_id, wb_data, wb_exc, commit_ready, flush,
    input  alloc_ready, alloc_id, commit_valid, commit_id, commit_dst_reg,
    input  commit_data, commit_we, commit_is_store, commit_exc, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_dst_reg, alloc_we, alloc_is_store,
    input  wb_valid, wb_id, wb_data, wb_exc, commit_ready, flush,
    output alloc_ready, alloc_id, commit_valid, commit_id, commit_dst_reg,
    output commit_data, commit_we, commit_is_store, commit_exc, count, empty, full
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail in program order, accepts
// out-of-order results by ID, and retires completed entries from the head.
module reorder_buffer
  import constants_pkg::*;
  import instruction_pkg::*;
#(
  parameter  int DEPTH  = ROB_DEPTH,
  parameter  int DATA_W = ARCH_LEN,
  parameter  int REG_W  = $clog2(REG_FILE_LEN),
  localparam int ID_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic [REG_W-1:0]  alloc_dst_reg_i,
  input  logic              alloc_we_i,
  input  logic              alloc_is_store_i,
  output logic [ID_W-1:0]   alloc_id_o,
  input  logic              wb_valid_i,
  input  logic [ID_W-1:0]   wb_id_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              wb_exc_i,
  output logic              commit_valid_o,
  input  logic              commit_ready_i,
  output logic [ID_W-1:0]   commit_id_o,
  output logic [REG_W-1:0]  commit_dst_reg_o,
  output logic [DATA_W-1:0] commit_data_o,
  output logic              commit_we_o,
  output logic              commit_is_store_o,
  output logic              commit_exc_o,
  input  logic              flush_i,
  output logic [ID_W:0]     count_o,
  output logic              empty_o,
  output logic              full_o
);

  rob_entry_t      mem [DEPTH];
  rob_entry_t      head_entry;
  logic [ID_W:0]   head_reg;
  logic [ID_W:0]   tail_reg;
  logic [ID_W-1:0] head_idx;
  logic [ID_W-1:0] tail_idx;
  logic            alloc_fire;
  logic            commit_fire;

  assign head_idx   = head_reg[ID_W-1:0];
  assign tail_idx   = tail_reg[ID_W-1:0];
  assign head_entry = mem[head_idx];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (head_reg[ID_W] != tail_reg[ID_W]) && (head_idx == tail_idx);
  assign empty_o = (head_reg == tail_reg);
  assign count_o = tail_reg - head_reg;

  assign alloc_ready_o = !full_o;
  assign alloc_id_o    = tail_idx;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  assign commit_valid_o    = head_entry.busy && head_entry.done;
  assign commit_fire       = commit_valid_o && commit_ready_i;
  assign commit_id_o       = head_idx;
  assign commit_dst_reg_o  = REG_W'(head_entry.dst_reg);
  assign commit_data_o     = DATA_W'(head_entry.data);
  assign commit_we_o       = head_entry.we;
  assign commit_is_store_o = head_entry.is_store;
  assign commit_exc_o      = head_entry.exc;

  // Only the status bits are reset; payload fields hold until rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg <= '0;
      tail_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].busy <= 1'b0;
        mem[i].done <= 1'b0;
        mem[i].exc  <= 1'b0;
      end
    end else if (flush_i) begin
      head_reg <= '0;
      tail_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].busy <= 1'b0;
        mem[i].done <= 1'b0;
        mem[i].exc  <= 1'b0;
      end
    end else begin
      // Allocation only targets a free slot, and writeback only a busy one,
      // so the two can never collide on the same entry.
      if (wb_valid_i && mem[wb_id_i].busy) begin
        mem[wb_id_i].done <= 1'b1;
        mem[wb_id_i].exc  <= wb_exc_i;
        mem[wb_id_i].data <= ARCH_LEN'(wb_data_i);
      end
      if (commit_fire) begin
        mem[head_idx].busy <= 1'b0;
        mem[head_idx].done <= 1'b0;
        head_reg           <= head_reg + 1'b1;
      end
      if (alloc_fire) begin
        mem[tail_idx].busy     <= 1'b1;
        mem[tail_idx].done     <= 1'b0;
        mem[tail_idx].exc      <= 1'b0;
        mem[tail_idx].we       <= alloc_we_i;
        mem[tail_idx].is_store <= alloc_is_store_i;
        mem[tail_idx].dst_reg  <= ENTRY_REG_W'(alloc_dst_reg_i);
        tail_reg               <= tail_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus randomized bench for reorder_buffer against a queue-based
// model of in-order retirement with out-of-order completion.
module tb_reorder_buffer;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct {
    int          id;
    int          dst;
    bit          we;
    bit          st;
    bit          done;
    logic [31:0] data;
    bit          exc;
  } ment_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    errors = 0;
  int    checks = 0;
  ment_t q[$];
  int    head_id = 0;
  logic [31:0] held_data;

  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_valid_i    (bus.alloc_valid),
    .alloc_ready_o    (bus.alloc_ready),
    .alloc_dst_reg_i  (bus.alloc_dst_reg),
    .alloc_we_i       (bus.alloc_we),
    .alloc_is_store_i (bus.alloc_is_store),
    .alloc_id_o       (bus.alloc_id),
    .wb_valid_i       (bus.wb_valid),
    .wb_id_i          (bus.wb_id),
    .wb_data_i        (bus.wb_data),
    .wb_exc_i         (bus.wb_exc),
    .commit_valid_o   (bus.commit_valid),
    .commit_ready_i   (bus.commit_ready),
    .commit_id_o      (bus.commit_id),
    .commit_dst_reg_o (bus.commit_dst_reg),
    .commit_data_o    (bus.commit_data),
    .commit_we_o      (bus.commit_we),
    .commit_is_store_o(bus.commit_is_store),
    .commit_exc_o     (bus.commit_exc),
    .flush_i          (bus.flush),
    .count_o          (bus.count),
    .empty_o          (bus.empty),
    .full_o           (bus.full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int  sz;
    bit  cv;
    sz = q.size();
    cv = (sz > 0) && q[0].done;
    chk({tag, ".ready"}, bus.alloc_ready, sz < DEPTH);
    chk({tag, ".alloc_id"}, bus.alloc_id, (head_id + sz) % DEPTH);
    chk({tag, ".count"}, bus.count, sz);
    chk({tag, ".empty"}, bus.empty, sz == 0);
    chk({tag, ".full"}, bus.full, sz == DEPTH);
    chk({tag, ".commit_valid"}, bus.commit_valid, cv);
    if (cv) begin
      chk({tag, ".commit_id"}, bus.commit_id, head_id);
      chk({tag, ".commit_dst"}, bus.commit_dst_reg, q[0].dst);
      chk({tag, ".commit_data"}, bus.commit_data, q[0].data);
      chk({tag, ".commit_we"}, bus.commit_we, q[0].we);
      chk({tag, ".commit_st"}, bus.commit_is_store, q[0].st);
      chk({tag, ".commit_exc"}, bus.commit_exc, q[0].exc);
    end
  endtask

  // Check outputs for the current state, clock once, then advance the model.
  task automatic step(input string tag);
    bit    av, wbv, wbe, cr, fl, cv, can_alloc;
    int    wid, tail_id;
    logic [31:0] wd;
    ment_t e;
    check_all(tag);
    av = bus.alloc_valid; wbv = bus.wb_valid; wid = int'(bus.wb_id);
    wd = bus.wb_data; wbe = bus.wb_exc; cr = bus.commit_ready; fl = bus.flush;
    e.id = 0; e.dst = int'(bus.alloc_dst_reg); e.we = bus.alloc_we;
    e.st = bus.alloc_is_store; e.done = 0; e.data = '0; e.exc = 0;
    @(posedge clk);
    cv = (q.size() > 0) && q[0].done;
    can_alloc = q.size() < DEPTH;
    tail_id = (head_id + q.size()) % DEPTH;
    if (fl) begin
      q.delete();
      head_id = 0;
    end else begin
      if (wbv)
        foreach (q[k])
          if (q[k].id == wid) begin
            q[k].done = 1; q[k].data = wd; q[k].exc = wbe;
          end
      if (cv && cr) begin
        void'(q.pop_front());
        head_id = (head_id + 1) % DEPTH;
      end
      if (av && can_alloc) begin
        e.id = tail_id;
        q.push_back(e);
      end
    end
    $display("[%0t] %s count=%0d commit_valid=%0b", $time, tag, bus.count, bus.commit_valid);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 0; bus.alloc_dst_reg = '0; bus.alloc_we = 0;
    bus.alloc_is_store = 0; bus.wb_valid = 0; bus.wb_id = '0;
    bus.wb_data = '0; bus.wb_exc = 0; bus.commit_ready = 0; bus.flush = 0;
  endtask

  task automatic set_alloc(input bit v);
    bus.alloc_valid = v;
    bus.alloc_dst_reg = REG_W'($urandom_range(0, 31));
    bus.alloc_we = 1'($urandom);
    bus.alloc_is_store = 1'($urandom);
  endtask

  task automatic set_wb(input bit v, input int id, input logic [31:0] d, input bit x);
    bus.wb_valid = v; bus.wb_id = 3'(id); bus.wb_data = d; bus.wb_exc = x;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ready", bus.alloc_ready, 1'b1);
    chk("reset.alloc_id", bus.alloc_id, 0);
    chk("reset.commit_valid", bus.commit_valid, 1'b0);
    chk("reset.count", bus.count, 0);
    chk("reset.empty", bus.empty, 1'b1);
    chk("reset.full", bus.full, 1'b0);
    rst_n = 1'b1;

    // In-order commit of out-of-order results.
    bus.commit_ready = 1;
    for (int i = 0; i < 3; i++) begin set_alloc(1); step("ooo_alloc"); end
    set_alloc(0);
    set_wb(1, 2, 32'h30, 0); step("ooo_wb2");
    set_wb(1, 1, 32'h20, 0); step("ooo_wb1");
    chk("ooo.not_yet", bus.commit_valid, 1'b0);
    set_wb(1, 0, 32'h10, 0); step("ooo_wb0");
    set_wb(0, 0, 0, 0);
    chk("ooo.first", bus.commit_data, 32'h10);
    step("ooo_c0");
    chk("ooo.second", bus.commit_data, 32'h20);
    step("ooo_c1");
    chk("ooo.third", bus.commit_data, 32'h30);
    step("ooo_c2");

    // Fill, then commit one and reuse the wrapped slot.
    bus.flush = 1; step("flush0"); bus.flush = 0;
    bus.commit_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin set_alloc(1); step("fill"); end
    chk("fill.full", bus.full, 1'b1);
    chk("fill.ready", bus.alloc_ready, 1'b0);
    chk("fill.count", bus.count, DEPTH);
    set_alloc(0); set_wb(1, 0, 32'hA0, 0); step("fill_wb0");
    set_wb(0, 0, 0, 0); bus.commit_ready = 1; set_alloc(1);
    step("fill_commit");
    bus.commit_ready = 0;
    chk("wrap.alloc_id", bus.alloc_id, 0);
    step("wrap_alloc");
    chk("wrap.count", bus.count, DEPTH);
    set_alloc(0);

    // Backpressure on commit keeps the head stable.
    for (int i = 1; i <= 3; i++) begin
      set_wb(1, i, $urandom, 0); step("bp_wb");
    end
    set_wb(0, 0, 0, 0);
    held_data = bus.commit_data;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      chk("bp.valid", bus.commit_valid, 1'b1);
      chk("bp.stable", bus.commit_data, held_data);
    end
    bus.commit_ready = 1;
    for (int i = 0; i < 3; i++) step("bp_pop");
    bus.commit_ready = 0;

    // Flush beats simultaneous allocate, writeback and commit.
    chk("flush.pre_count", bus.count, 5);
    bus.flush = 1; set_alloc(1); set_wb(1, 4, 32'hDEAD, 0); bus.commit_ready = 1;
    step("flush5");
    idle();
    chk("flush.empty", bus.empty, 1'b1);
    chk("flush.count", bus.count, 0);
    chk("flush.commit_valid", bus.commit_valid, 1'b0);

    // Writeback to an empty buffer is ignored; exception reaches commit.
    set_wb(1, 3, 32'h55, 1); step("wb_empty");
    chk("wb_empty.empty", bus.empty, 1'b1);
    set_wb(0, 0, 0, 0); set_alloc(1); step("exc_alloc");
    set_alloc(0); set_wb(1, 0, 32'h77, 1); step("exc_wb");
    set_wb(0, 0, 0, 0);
    chk("exc.commit_exc", bus.commit_exc, 1'b1);
    bus.commit_ready = 1; step("exc_pop");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      set_alloc($urandom_range(0, 2) != 0);
      if (q.size() > 0 && $urandom_range(0, 9) < 7)
        set_wb(1, q[$urandom_range(0, q.size() - 1)].id, $urandom, 1'($urandom_range(0, 7) == 0));
      else
        set_wb(1'($urandom), $urandom_range(0, DEPTH - 1), $urandom, 1'($urandom));
      bus.commit_ready = 1'($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 40) == 0);
      step("rand");
    end

    // Asynchronous reset mid-cycle with entries in flight.
    idle();
    bus.flush = 1; step("pre_rst_flush"); bus.flush = 0;
    for (int i = 0; i < 4; i++) begin set_alloc(1); step("pre_rst_alloc"); end
    set_alloc(0);
    chk("pre_rst.count", bus.count, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.ready", bus.alloc_ready, 1'b1);
    chk("arst.alloc_id", bus.alloc_id, 0);
    chk("arst.commit_valid", bus.commit_valid, 1'b0);
    chk("arst.count", bus.count, 0);
    chk("arst.empty", bus.empty, 1'b1);
    chk("arst.full", bus.full, 1'b0);
    q.delete();
    head_id = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    set_alloc(1); step("post_rst");
    set_alloc(0); step("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
